// File: rtl/riscv_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// Funct3 size/sign encodings, request legality, lane enables and load extension.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when a request may proceed to the array.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    if (rd && wr)
      ok = 1'b0;
    else if (wr) begin
      if (!(f3 inside {F3_B, F3_H, F3_W})) ok = 1'b0;
    end else begin
      if (!(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) ok = 1'b0;
    end
    // Halfwords need even addresses, words need 4-byte alignment.
    if (f3[1:0] == 2'b01 && off[0]) ok = 1'b0;
    if (f3 == F3_W && off != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  // Byte-lane enables of a store.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Select the addressed lane(s) of a word and extend according to Funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'd0, b};
      F3_HU:   return {16'd0, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array: synchronous read, 4-lane byte-enable write.
module dmem_sram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  // Write enabled lanes, or register the addressed word on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) mem[addr][l] <= wdata[8*l +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the
// controller, rejects illegal requests with Err, completes legal ones with Done.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e   state_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          done_q, err_q;

  logic          req_v, req_ok, rd_go;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  // Upper address bits alias onto the array.
  logic unused_ok;
  assign unused_ok = ^Addr[31:AW+2];

  // While Err is showing the requester is still holding the rejected
  // request, so it is not looked at again until it has been dropped.
  assign req_v  = (state_q == IDLE) && (MemRead || MemWrite) && !err_q;
  assign req_ok = req_legal(MemRead, MemWrite, Funct3, Addr[1:0]);
  assign rd_go  = req_v && req_ok && MemRead;

  // The read is launched from IDLE so the word is ready during RD and
  // the extended result can be registered on the RD->RESP edge.
  // Writes happen in WR even under reset, so an in-flight store completes.
  assign sram_we   = (state_q == WR);
  assign sram_en   = rd_go || sram_we;
  assign sram_addr = (state_q == IDLE) ? Addr[AW+1:2] : addr_q[AW+1:2];

  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .be    (store_be(f3_q, addr_q[1:0])),
    .addr  (sram_addr),
    .wdata (store_data(f3_q, wdata_q)),
    .rdata (sram_rdata)
  );

  // Control FSM with registered Done/Err/RdData.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_v) begin
            if (!req_ok) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= Addr[AW+1:0];
              f3_q    <= Funct3;
              wdata_q <= WrData;
              state_q <= MemWrite ? WR : RD;
            end
          end
        end
        RD: begin
          rdata_q <= load_ext(sram_rdata, f3_q, addr_q[1:0]);
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        WR: begin
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RdData = rdata_q;
  assign Done   = done_q;
  assign Err    = err_q;
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single requests plus
// hand-written reset and back-to-back sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic [31:0] RdData;
  logic        Busy, Done, Err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(256)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WrData(WrData),
    .RdData(RdData), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop();
    MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One request from IDLE through completion or rejection.
  task automatic run_req(input vec_t v, input string tag);
    step();
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3; Addr = v.addr; WrData = v.wdata;
    step();
    if (v.err) begin
      chk({tag, "_err"},  32'(Err),  32'd1);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
      drop();
      step();
      chk({tag, "_err_off"}, 32'(Err), 32'd0);
      chk({tag, "_rdata"},   RdData,   v.rdata);
    end else begin
      chk({tag, "_busy1"}, 32'(Busy), 32'd1);
      chk({tag, "_early"}, 32'(Done), 32'd0);
      chk({tag, "_noerr"}, 32'(Err),  32'd0);
      step();
      chk({tag, "_done"},  32'(Done), 32'd1);
      chk({tag, "_busy2"}, 32'(Busy), 32'd1);
      chk({tag, "_rdata"}, RdData,    v.rdata);
      drop();
      step();
      chk({tag, "_done_off"}, 32'(Done), 32'd0);
      chk({tag, "_idle"},     32'(Busy), 32'd0);
    end
  endtask

  initial begin
    //        rd wr f3      addr          wdata         err rdata
    vt[0]  = '{0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0};
    vt[1]  = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    vt[2]  = '{0, 1, 3'b000, 32'h13,  32'h00000080, 0, 32'hDEADBEEF};
    vt[3]  = '{1, 0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFF80};
    vt[4]  = '{1, 0, 3'b100, 32'h13,  32'h0,        0, 32'h00000080};
    vt[5]  = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF};
    vt[6]  = '{1, 0, 3'b001, 32'h11,  32'h0,        1, 32'h80ADBEEF};
    vt[7]  = '{0, 1, 3'b010, 32'h22,  32'h55555555, 1, 32'h80ADBEEF};
    vt[8]  = '{1, 1, 3'b010, 32'h10,  32'h11111111, 1, 32'h80ADBEEF};
    vt[9]  = '{1, 0, 3'b011, 32'h10,  32'h0,        1, 32'h80ADBEEF};
    vt[10] = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF};
    vt[11] = '{0, 1, 3'b010, 32'h400, 32'h12345678, 0, 32'h80ADBEEF};
    vt[12] = '{1, 0, 3'b010, 32'h0,   32'h0,        0, 32'h12345678};
    vt[13] = '{0, 1, 3'b001, 32'h16,  32'h0000ABCD, 0, 32'h12345678};
    vt[14] = '{1, 0, 3'b001, 32'h16,  32'h0,        0, 32'hFFFFABCD};
    vt[15] = '{1, 0, 3'b101, 32'h16,  32'h0,        0, 32'h0000ABCD};
    vt[16] = '{1, 0, 3'b000, 32'h10,  32'h0,        0, 32'hFFFFFFEF};
    vt[17] = '{1, 0, 3'b000, 32'h12,  32'h0,        0, 32'hFFFFFFAD};
    vt[18] = '{1, 0, 3'b100, 32'h11,  32'h0,        0, 32'h000000BE};
    vt[19] = '{1, 0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFF80AD};
    vt[20] = '{1, 0, 3'b101, 32'h10,  32'h0,        0, 32'h0000BEEF};
    vt[21] = '{0, 1, 3'b100, 32'h10,  32'h0,        1, 32'h0000BEEF};
    vt[22] = '{1, 0, 3'b110, 32'h10,  32'h0,        1, 32'h0000BEEF};
    vt[23] = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF};

    drop();
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_rdata", RdData,     32'h0);
    chk("rst_busy",  32'(Busy),  32'd0);
    chk("rst_done",  32'(Done),  32'd0);
    chk("rst_err",   32'(Err),   32'd0);

    foreach (vt[i]) run_req(vt[i], $sformatf("v%0d", i));

    // Reset while a load is in RD: discarded, no Done.
    step();
    MemRead = 1; Funct3 = 3'b010; Addr = 32'h10;
    step();
    chk("rrd_busy", 32'(Busy), 32'd1);
    reset = 1; drop();
    step();
    reset = 0;
    chk("rrd_done",  32'(Done), 32'd0);
    chk("rrd_rdata", RdData,    32'h0);
    chk("rrd_busy0", 32'(Busy), 32'd0);
    run_req('{1, 0, 3'b010, 32'h0, 32'h0, 0, 32'h12345678}, "rrd_after");

    // Reset while a store is in WR: the write still lands.
    step();
    MemWrite = 1; Funct3 = 3'b010; Addr = 32'h30; WrData = 32'hCAFEF00D;
    step();
    chk("rwr_busy", 32'(Busy), 32'd1);
    reset = 1; drop();
    step();
    reset = 0;
    chk("rwr_done",  32'(Done), 32'd0);
    chk("rwr_busy0", 32'(Busy), 32'd0);
    run_req('{1, 0, 3'b010, 32'h30, 32'h0, 0, 32'hCAFEF00D}, "rwr_after");

    // Load held through RESP, then a store in the first IDLE cycle.
    step();
    MemRead = 1; Funct3 = 3'b010; Addr = 32'h10;
    step();
    chk("b2b_ld_busy", 32'(Busy), 32'd1);
    step();
    chk("b2b_ld_done",  32'(Done), 32'd1);
    chk("b2b_ld_rdata", RdData,    32'h80ADBEEF);
    step();
    chk("b2b_idle_done", 32'(Done), 32'd0);
    chk("b2b_idle_busy", 32'(Busy), 32'd0);
    MemRead = 0; MemWrite = 1; Funct3 = 3'b010; Addr = 32'h40; WrData = 32'h11223344;
    step();
    chk("b2b_st_busy", 32'(Busy), 32'd1);
    chk("b2b_st_early", 32'(Done), 32'd0);
    step();
    chk("b2b_st_done",  32'(Done), 32'd1);
    chk("b2b_st_rdata", RdData,    32'h80ADBEEF);
    drop();
    step();
    chk("b2b_end_done", 32'(Done), 32'd0);
    chk("b2b_end_busy", 32'(Busy), 32'd0);
    run_req('{1, 0, 3'b010, 32'h40, 32'h0, 0, 32'h11223344}, "b2b_verify");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
